// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade player-input front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arcade_input_pkg;

    // Bit positions inside one player's 16-bit joystick word
    localparam int JS_RIGHT = 0;
    localparam int JS_LEFT  = 1;
    localparam int JS_DOWN  = 2;
    localparam int JS_UP    = 3;
    localparam int JS_COIN  = 4;
    localparam int JS_START = 5;
    localparam int JS_BITS  = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } coin_state_t;

endpackage

// File: rtl/input_debounce.sv
// Single-bit debouncer: output follows raw once it has differed for DEBOUNCE consecutive samples.
// Latency: DEBOUNCE cycles (1 registered cycle when DEBOUNCE=0).
// Backpressure: none, raw is sampled every clock.
// Ports: clk, reset (async, active-high), raw (pressed=1), held (debounced, pressed=1).
module input_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic held
);

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            always_ff @(posedge clk or posedge reset) begin
                if (reset) held <= 1'b0;
                else       held <= raw;
            end
        end else begin : g_filter
            localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
            localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE - 1);

            logic [CW-1:0] cnt;

            // Counter tracks how long raw has disagreed with held; any agreement restarts it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    held <= 1'b0;
                    cnt  <= '0;
                end else if (raw == held) begin
                    cnt <= '0;
                end else if (cnt == CLAST) begin
                    held <= raw;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player-input / DIP front end: DIP byte capture, per-bit debounce, frame-synchronous coin pulses.
// Latency: DIP 1 cycle; buttons DEBOUNCE cycles; coin pulse from debounced press +2 cycles.
// Backpressure: none; coin presses are queued (up to 3) while a pulse or gap is in progress.
// Ports: clk, reset (async high); ioctl_* download stream; joystick (16 bits/player); vblank;
//        dip/dip_valid; dirs {up,down,left,right}/player; coin; start/player; coin_count.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int NUM_DIP_BYTES = 8,
    parameter int DIP_INDEX     = 254,
    parameter int DEBOUNCE      = 16,
    parameter int COIN_FRAMES   = 3,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ioctl_wr,
    input  logic [7:0]                 ioctl_index,
    input  logic [24:0]                ioctl_addr,
    input  logic [7:0]                 ioctl_dout,
    input  logic [16*NUM_PLAYERS-1:0]  joystick,
    input  logic                       vblank,
    output logic [8*NUM_DIP_BYTES-1:0] dip,
    output logic                       dip_valid,
    output logic [4*NUM_PLAYERS-1:0]   dirs,
    output logic                       coin,
    output logic [NUM_PLAYERS-1:0]     start,
    output logic [15:0]                coin_count
);

    localparam logic AL = (ACTIVE_LOW != 0);
    localparam int   FW = (COIN_FRAMES > 1) ? $clog2(COIN_FRAMES) : 1;
    localparam logic [FW-1:0] FLAST = FW'(COIN_FRAMES - 1);

    // ---------------- DIP capture ----------------
    logic dip_hit;
    assign dip_hit = ioctl_wr && (ioctl_index == 8'(DIP_INDEX))
                     && (ioctl_addr < 25'(NUM_DIP_BYTES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dip       <= '0;
            dip_valid <= 1'b0;
        end else if (dip_hit) begin
            for (int k = 0; k < NUM_DIP_BYTES; k++) begin
                if (ioctl_addr[2:0] == 3'(k)) dip[8*k +: 8] <= ioctl_dout;
            end
            if (ioctl_addr[2:0] == 3'(NUM_DIP_BYTES - 1)) dip_valid <= 1'b1;
        end
    end

    // ---------------- Debounce (held state is pressed=1) ----------------
    logic [JS_BITS*NUM_PLAYERS-1:0] held;
    logic [NUM_PLAYERS-1:0]         unused_js;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        for (genvar b = 0; b < JS_BITS; b++) begin : g_bit
            input_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
                .clk   (clk),
                .reset (reset),
                .raw   (joystick[16*p + b]),
                .held  (held[JS_BITS*p + b])
            );
        end
        assign unused_js[p] = ^joystick[16*p + JS_BITS +: 16 - JS_BITS];
    end

    logic coin_req;

    always_comb begin
        dirs     = '0;
        start    = '0;
        coin_req = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            dirs[4*p +: 4] = held[JS_BITS*p +: 4] ^ {4{AL}};
            start[p]       = held[JS_BITS*p + JS_START] ^ AL;
            coin_req       = coin_req | held[JS_BITS*p + JS_COIN];
        end
    end

    // ---------------- Coin shaping ----------------
    logic        coin_req_q, vblank_q;
    logic        coin_rise, tick, frame_done;
    logic [1:0]  pending;
    logic [FW-1:0] fcnt;
    coin_state_t state, state_nxt;
    logic        take, coin_on, inc_ok;

    assign coin_rise  = coin_req & ~coin_req_q;
    assign tick       = vblank & ~vblank_q;
    assign frame_done = tick && (fcnt == FLAST);
    assign inc_ok     = coin_rise && (pending != 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coin_req_q <= 1'b0;
            vblank_q   <= 1'b0;
        end else begin
            coin_req_q <= coin_req;
            vblank_q   <= vblank;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending != 2'd0) state_nxt = ACTIVE;
            ACTIVE:  if (frame_done)      state_nxt = GAP;
            GAP:     if (frame_done)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        coin_on = (state == ACTIVE);
        take    = (state == IDLE) && (pending != 2'd0);
        coin    = coin_on ^ AL;
    end

    // Frame counter restarts on every state change so ACTIVE and GAP each span COIN_FRAMES ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    fcnt <= '0;
        else if (state_nxt != state)  fcnt <= '0;
        else if (tick && state != IDLE) fcnt <= fcnt + FW'(1);
    end

    // Simultaneous press and pulse start cancel; a press at saturation is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 2'd0;
            coin_count <= 16'd0;
        end else begin
            case ({inc_ok, take})
                2'b10:   pending <= pending + 2'd1;
                2'b01:   pending <= pending - 2'd1;
                default: pending <= pending;
            endcase
            if (take) coin_count <= coin_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl: reference model for the default build plus a
// second build (4 players, active-high, no debounce, 4 DIP bytes) checked with literals.
// Runs to completion on its own and prints a single summary line.
module tb_arcade_input_ctrl;

    localparam int NP = 2;
    localparam int CF = 3;
    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic [31:0] joystick = 32'd0;
    logic [63:0] joystick_b = 64'd0;
    logic        vblank = 1'b0;

    logic [63:0] dip;
    logic        dip_valid, coin;
    logic [7:0]  dirs;
    logic [1:0]  start;
    logic [15:0] coin_count;

    logic [31:0] dip_b;
    logic        dip_valid_b, coin_b;
    logic [15:0] dirs_b;
    logic [3:0]  start_b;
    logic [15:0] coin_count_b;

    arcade_input_ctrl #(
        .NUM_PLAYERS(NP), .NUM_DIP_BYTES(8), .DIP_INDEX(254),
        .DEBOUNCE(DB), .COIN_FRAMES(CF), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .joystick(joystick),
        .vblank(vblank), .dip(dip), .dip_valid(dip_valid), .dirs(dirs), .coin(coin),
        .start(start), .coin_count(coin_count)
    );

    arcade_input_ctrl #(
        .NUM_PLAYERS(4), .NUM_DIP_BYTES(4), .DIP_INDEX(254),
        .DEBOUNCE(0), .COIN_FRAMES(1), .ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .reset(reset), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .joystick(joystick_b),
        .vblank(vblank), .dip(dip_b), .dip_valid(dip_valid_b), .dirs(dirs_b), .coin(coin_b),
        .start(start_b), .coin_count(coin_count_b)
    );

    int vectors = 0;
    int miscompares = 0;
    bit vb_en = 1'b0;
    bit vb_last = 1'b0;
    bit pend_tick = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    initial forever #5 clk = ~clk;

    // Frame generator: vblank high for 10 of every 100 cycles while enabled.
    initial begin : vb_gen
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #3;
            if (vb_en) begin
                ph = (ph + 1) % 100;
                vblank = (ph < 10);
            end else begin
                ph = 0;
                vblank = 1'b0;
            end
        end
    end

    // ---------------- Reference model of the default build ----------------
    bit [7:0]  m_dip [8];
    bit        m_dip_valid;
    bit        m_btn [NP][6];
    int        m_run [NP][6];
    bit        m_prev_req, m_prev_vb;
    int        m_queue;      // presses waiting for a pulse
    int        m_busy;       // ticks left in pulse+gap; pulse is on while above CF
    bit [15:0] m_count;

    initial forever begin : model
        bit old_req, rise, tick, go;
        @(posedge clk or posedge reset);
        if (reset) begin
            for (int k = 0; k < 8; k++) m_dip[k] = 8'd0;
            m_dip_valid = 0;
            for (int p = 0; p < NP; p++)
                for (int b = 0; b < 6; b++) begin m_btn[p][b] = 0; m_run[p][b] = 0; end
            m_prev_req = 0; m_prev_vb = 0; m_queue = 0; m_busy = 0; m_count = 0;
        end else begin
            old_req = m_btn[0][4] | m_btn[1][4];
            rise = old_req && !m_prev_req;
            m_prev_req = old_req;
            tick = vblank && !m_prev_vb;
            m_prev_vb = vblank;
            go = (m_busy == 0) && (m_queue != 0);
            if (go) begin
                m_busy = 2 * CF;
                m_count = m_count + 16'd1;
            end else if (m_busy > 0 && tick) begin
                m_busy = m_busy - 1;
            end
            m_queue = m_queue + ((rise && m_queue < 3) ? 1 : 0) - (go ? 1 : 0);
            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8) begin
                m_dip[ioctl_addr[2:0]] = ioctl_dout;
                if (ioctl_addr == 25'd7) m_dip_valid = 1;
            end
            for (int p = 0; p < NP; p++)
                for (int b = 0; b < 6; b++) begin
                    if (joystick[16*p+b] != m_btn[p][b]) begin
                        m_run[p][b]++;
                        if (m_run[p][b] == DB) begin
                            m_btn[p][b] = joystick[16*p+b];
                            m_run[p][b] = 0;
                        end
                    end else begin
                        m_run[p][b] = 0;
                    end
                end
        end
    end

    initial forever begin : compare
        logic [7:0]  ed;
        logic [1:0]  es;
        logic [63:0] edip;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < 4; b++) ed[4*p+b] = ~m_btn[p][b];
            es[p] = ~m_btn[p][5];
        end
        for (int k = 0; k < 8; k++) edip[8*k +: 8] = m_dip[k];
        check("model dip", dip, edip);
        check("model dip_valid", 64'(dip_valid), 64'(m_dip_valid));
        check("model dirs", 64'(dirs), 64'(ed));
        check("model start", 64'(start), 64'(es));
        check("model coin", 64'(coin), (m_busy > CF) ? 64'd0 : 64'd1);
        check("model coin_count", 64'(coin_count), 64'(m_count));
    end

    // ---------------- Stimulus helpers ----------------
    task automatic dip_wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        @(posedge clk); #3;
        ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
        @(posedge clk); #3;
        ioctl_wr = 1'b0;
    endtask

    task automatic press_coin();
        @(negedge clk); #1 joystick[4] = 1'b1;
        repeat (20) @(negedge clk);
        #1 joystick[4] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    // Advance to the next falling edge; pend_tick says a vblank rise will be seen at the next rising edge.
    task automatic step_neg();
        @(negedge clk);
        pend_tick = vblank && !vb_last;
        vb_last = vblank;
    endtask

    task automatic measure(output int act, output int gap, input bit want_gap);
        int guard;
        act = 0; gap = 0;
        vb_last = vblank;
        step_neg();
        guard = 0;
        while (coin !== 1'b0 && guard < 3000) begin step_neg(); guard++; end
        check("pulse start timeout", 64'(guard >= 3000), 64'd0);
        guard = 0;
        while (coin === 1'b0 && guard < 3000) begin
            if (pend_tick) act++;
            step_neg(); guard++;
        end
        check("pulse end timeout", 64'(guard >= 3000), 64'd0);
        if (want_gap) begin
            guard = 0;
            while (coin === 1'b1 && guard < 3000) begin
                if (pend_tick) gap++;
                step_neg(); guard++;
            end
            check("gap end timeout", 64'(guard >= 3000), 64'd0);
        end
    endtask

    task automatic watch_idle(input int cycles, output int lows);
        lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (coin !== 1'b1) lows++;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- Directed sequence ----------------
    initial begin : main
        int act, gap, lows;
        reset = 1'b1;
        #1;
        check("reset dip", dip, 64'd0);
        check("reset dip_valid", 64'(dip_valid), 64'd0);
        check("reset dirs", 64'(dirs), 64'hFF);
        check("reset start", 64'(start), 64'h3);
        check("reset coin", 64'(coin), 64'd1);
        check("reset coin_count", 64'(coin_count), 64'd0);
        check("b reset dirs", 64'(dirs_b), 64'd0);
        check("b reset start", 64'(start_b), 64'd0);
        check("b reset coin", 64'(coin_b), 64'd0);
        check("b reset dip", 64'(dip_b), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;

        // DIP load
        for (int k = 0; k < 8; k++) begin
            dip_wr(8'd254, 25'(k), 8'((k + 1) * 17));
            @(negedge clk);
            check("dip_valid after write", 64'(dip_valid), 64'(k == 7));
            check("b dip_valid after write", 64'(dip_valid_b), 64'(k >= 3));
        end
        check("dip loaded", dip, 64'h8877665544332211);
        check("b dip loaded", 64'(dip_b), 64'h44332211);
        dip_wr(8'd254, 25'd9, 8'hEE);
        dip_wr(8'd254, 25'd8, 8'hEE);
        dip_wr(8'd0, 25'd0, 8'hEE);
        @(negedge clk);
        check("dip after ignored writes", dip, 64'h8877665544332211);

        // Debounce: glitch of 10 samples then stable high
        @(negedge clk); #1 joystick[3] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("glitch up held", 64'(dirs[3]), 64'd1);
        end
        #1 joystick[3] = 1'b0;
        repeat (3) @(negedge clk);
        #1 joystick[3] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("stable up", 64'(dirs[3]), (i < 16) ? 64'd1 : 64'd0);
        end
        #1 joystick[3] = 1'b0;
        repeat (20) @(negedge clk);

        // Mixed pattern across both players
        #1 joystick = 32'h0021_0005;
        repeat (17) @(negedge clk);
        check("mixed dirs", 64'(dirs), 64'hEA);
        check("mixed start", 64'(start), 64'h1);
        #1 joystick = 32'd0;
        repeat (20) @(negedge clk);

        // Single coin with frames running
        vb_en = 1'b1;
        fork
            press_coin();
            measure(act, gap, 1'b0);
        join
        check("single pulse ticks", 64'(act), 64'd3);
        watch_idle(700, lows);
        check("single no extra pulse", 64'(lows), 64'd0);
        check("single coin_count", 64'(coin_count), 64'd1);

        // Burst of 5 presses inside one frame
        vb_en = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
        repeat (5) press_coin();
        check("burst first pulse on", 64'(coin), 64'd0);
        check("burst count before frames", 64'(coin_count), 64'd1);
        vb_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            measure(act, gap, i < 3);
            check("burst pulse ticks", 64'(act), 64'd3);
            if (i < 3) check("burst gap ticks", 64'(gap), 64'd3);
        end
        watch_idle(800, lows);
        check("burst no fifth pulse", 64'(lows), 64'd0);
        check("burst coin_count", 64'(coin_count), 64'd4);

        // Reset during an active pulse with one press queued
        vb_en = 1'b0;
        press_coin();
        press_coin();
        check("pre-reset pulse on", 64'(coin), 64'd0);
        @(negedge clk); #1 reset = 1'b1;
        #1;
        check("async reset coin", 64'(coin), 64'd1);
        check("async reset coin_count", 64'(coin_count), 64'd0);
        @(negedge clk); #1 reset = 1'b0;
        vb_en = 1'b1;
        watch_idle(800, lows);
        check("no pulse after reset", 64'(lows), 64'd0);
        fork
            press_coin();
            measure(act, gap, 1'b0);
        join
        check("post-reset pulse ticks", 64'(act), 64'd3);
        check("post-reset coin_count", 64'(coin_count), 64'd1);
        vb_en = 1'b0;

        // Reset mid-download
        for (int k = 0; k < 4; k++) dip_wr(8'd254, 25'(k), 8'(8'hA0 + k));
        @(negedge clk); #1 reset = 1'b1;
        #1;
        check("mid-download reset dip", dip, 64'd0);
        check("mid-download reset dip_valid", 64'(dip_valid), 64'd0);
        check("b mid-download reset dip_valid", 64'(dip_valid_b), 64'd0);
        @(negedge clk); #1 reset = 1'b0;
        dip_wr(8'd254, 25'd7, 8'h5A);
        @(negedge clk);
        check("dip after reload", dip, 64'h5A00_0000_0000_0000);
        check("dip_valid after reload", 64'(dip_valid), 64'd1);
        check("b ignores addr 7", 64'(dip_valid_b), 64'd0);

        // Active-high build: P4 start and P2 left
        #1 joystick_b = 64'h0020_0000_0002_0000;
        #1;
        check("b start before edge", 64'(start_b), 64'd0);
        @(negedge clk);
        check("b start p4", 64'(start_b), 64'h8);
        check("b dirs p2 left", 64'(dirs_b), 64'h0020);
        check("b coin idle", 64'(coin_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
